// File: rtl/mem_irq_ctrl.sv
// mem_irq_ctrl
//   Word-addressed 32-bit RAM with a 16-word register window that holds a
//   down-counting timer and its level interrupt.
//
//   Parameters
//     SIZE      word-address width (RAM spans 2^SIZE words minus the window)
//     REG_BASE  first word address of the 16-word register window
//
//   Ports
//     clk           clock, all state changes on the rising edge
//     rst           synchronous active-high reset
//     wrEn          CPU write strobe
//     addr_toRAM    CPU word address
//     data_toRAM    CPU write data
//     data_fromRAM  registered read data (one cycle after the address, read-first)
//     interrupt     registered level interrupt (the PEND bit)
//
//   Register window (offset from REG_BASE)
//     +0 CTRL   bit0 EN, bit1 AUTO
//     +1 LOAD   reload value
//     +2 COUNT  current count, read-only
//     +3 STATUS bit0 PEND, write 1 to clear
//     +4..+15   reserved, read as zero
module mem_irq_ctrl #(
    parameter int              SIZE     = 14,
    parameter logic [SIZE-1:0] REG_BASE = 14'h3FF0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [SIZE-1:0] addr_toRAM,
    input  logic [31:0]     data_toRAM,
    output logic [31:0]     data_fromRAM,
    output logic            interrupt
);

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_RUN  = 2'd1;
    localparam logic [1:0] T_DONE = 2'd2;

    localparam int RAM_WORDS = 1 << SIZE;

    logic [31:0]     mem [RAM_WORDS];

    logic [SIZE-1:0] offset;
    logic            in_win;
    logic [3:0]      reg_sel;
    logic            ctrl_wr;
    logic            load_wr;
    logic            status_wr;
    logic            expire;
    logic [31:0]     reg_rdata;

    logic            ctrl_en;
    logic            ctrl_auto;
    logic [31:0]     load;
    logic [31:0]     count;
    logic            pend;
    logic [1:0]      state;

    // Window membership is tested on the offset so REG_BASE need not be
    // 16-word aligned.
    assign offset    = addr_toRAM - REG_BASE;
    assign in_win    = (offset < SIZE'(16));
    assign reg_sel   = offset[3:0];

    assign ctrl_wr   = wrEn && in_win && (reg_sel == 4'd0);
    assign load_wr   = wrEn && in_win && (reg_sel == 4'd1);
    assign status_wr = wrEn && in_win && (reg_sel == 4'd3);

    // Any CTRL write outranks an expiry on the same edge.
    assign expire    = !ctrl_wr && (state == T_RUN) && (count == 32'd0);

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_sel)
            4'd0:    reg_rdata = {30'd0, ctrl_auto, ctrl_en};
            4'd1:    reg_rdata = load;
            4'd2:    reg_rdata = count;
            4'd3:    reg_rdata = {31'd0, pend};
            default: reg_rdata = 32'd0;
        endcase
    end

    // RAM array: never reset, writes blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wrEn && !in_win) begin
            mem[addr_toRAM] <= data_toRAM;
        end
    end

    // Read port, registers and timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_fromRAM <= 32'd0;
            ctrl_en      <= 1'b0;
            ctrl_auto    <= 1'b0;
            load         <= 32'd0;
            count        <= 32'd0;
            pend         <= 1'b0;
            state        <= T_IDLE;
        end else begin
            // Old contents are sampled, giving read-first behaviour.
            data_fromRAM <= in_win ? reg_rdata : mem[addr_toRAM];

            if (load_wr) begin
                load <= data_toRAM;
            end

            if (ctrl_wr) begin
                ctrl_en   <= data_toRAM[0];
                ctrl_auto <= data_toRAM[1];
                if (data_toRAM[0]) begin
                    count <= load;
                    state <= T_RUN;
                end else begin
                    state <= T_IDLE;
                end
            end else if (state == T_RUN) begin
                if (count != 32'd0) begin
                    count <= count - 32'd1;
                end else if (ctrl_auto) begin
                    count <= load;
                end else begin
                    state   <= T_DONE;
                    ctrl_en <= 1'b0;
                end
            end

            // Expiry wins over a software clear on the same edge.
            if (expire) begin
                pend <= 1'b1;
            end else if (status_wr && data_toRAM[0]) begin
                pend <= 1'b0;
            end
        end
    end

    assign interrupt = pend;

endmodule

// File: tb/tb_mem_irq_ctrl.sv
module tb_mem_irq_ctrl;

    localparam int          SIZE     = 14;
    localparam logic [13:0] RB       = 14'h3FF0;
    localparam logic [13:0] A_CTRL   = RB;
    localparam logic [13:0] A_LOAD   = RB + 14'd1;
    localparam logic [13:0] A_COUNT  = RB + 14'd2;
    localparam logic [13:0] A_STATUS = RB + 14'd3;
    localparam logic [13:0] A_RSV9   = RB + 14'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [13:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural RAM image: only words the bench has written are known.
    logic [31:0] ram_m [int];

    mem_irq_ctrl #(.SIZE(SIZE), .REG_BASE(RB)) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .addr_toRAM  (addr),
        .data_toRAM  (din),
        .data_fromRAM(dout),
        .interrupt   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // One clock: drive, take the edge, settle 1 time unit past it.
    task automatic cyc(input logic we, input logic [13:0] a, input logic [31:0] d);
        wrEn = we;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 14'd0, 32'd0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic ram_wr(input logic [13:0] a, input logic [31:0] d);
        cyc(1'b1, a, d);
        ram_m[int'(a)] = d;
    endtask

    task automatic ram_rd(input string tag, input logic [13:0] a);
        cyc(1'b0, a, 32'd0);
        chk(tag, dout, ram_m[int'(a)]);
    endtask

    task automatic reg_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        cyc(1'b0, a, 32'd0);
        chk(tag, dout, exp);
    endtask

    int          pa [8];
    int          j;
    logic        we;
    logic [31:0] d;
    logic [31:0] exp;
    int          L;

    initial begin
        // Reset state
        rst = 1'b1; wrEn = 1'b0; addr = 14'd0; din = 32'd0;
        idle();
        idle();
        chk("rst_data", dout, 32'd0);
        chk_irq("rst_irq", 1'b0);
        rst = 1'b0;
        reg_rd("rst_ctrl",   A_CTRL,   32'd0);
        reg_rd("rst_load",   A_LOAD,   32'd0);
        reg_rd("rst_count",  A_COUNT,  32'd0);
        reg_rd("rst_status", A_STATUS, 32'd0);

        // RAM write then read
        ram_wr(14'h0005, 32'hDEADBEEF);
        ram_rd("ram_5", 14'h0005);

        // Read during write returns the old word
        ram_wr(14'h0007, 32'd1);
        cyc(1'b1, 14'h0007, 32'd2);
        chk("rdw_old", dout, 32'd1);
        ram_m[7] = 32'd2;
        ram_rd("rdw_new", 14'h0007);

        // Randomised RAM traffic over a small address pool
        for (int i = 0; i < 8; i++) begin
            pa[i] = int'($urandom_range(0, 32'h3FEF));
            ram_wr(14'(pa[i]), $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            j   = int'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            exp = ram_m[pa[j]];
            cyc(we, 14'(pa[j]), d);
            chk("ram_rand", dout, exp);
            if (we) ram_m[pa[j]] = d;
        end

        // Register window access
        wr(A_CTRL, 32'h0000_0002);
        reg_rd("win_ctrl", A_CTRL, 32'h2);
        wr(A_CTRL, 32'hFFFF_FFFC);
        reg_rd("win_ctrl_hi", A_CTRL, 32'h0);
        wr(A_LOAD, 32'h1234_5678);
        reg_rd("win_load", A_LOAD, 32'h1234_5678);
        wr(A_COUNT, 32'h0000_FFFF);
        reg_rd("win_count_ro", A_COUNT, 32'h0);
        wr(A_RSV9, 32'hA5A5_A5A5);
        reg_rd("win_rsv", A_RSV9, 32'h0);
        ram_rd("win_ram5", 14'h0005);
        ram_rd("win_ram7", 14'h0007);

        // One-shot: LOAD=3, enable at E0, COUNT 3,2,1,0, PEND at E4
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd1);
        reg_rd("os_cnt3", A_COUNT, 32'd3);
        reg_rd("os_cnt2", A_COUNT, 32'd2);
        reg_rd("os_cnt1", A_COUNT, 32'd1);
        chk_irq("os_irq_pre", 1'b0);
        reg_rd("os_cnt0", A_COUNT, 32'd0);
        chk_irq("os_irq", 1'b1);
        reg_rd("os_ctrl", A_CTRL, 32'd0);
        reg_rd("os_hold", A_COUNT, 32'd0);
        reg_rd("os_status", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd0);
        chk_irq("os_clr0", 1'b1);
        wr(A_STATUS, 32'd1);
        chk_irq("os_clr1", 1'b0);
        idle();
        chk_irq("os_stay", 1'b0);

        // Auto-reload: LOAD=1 gives PEND every second edge
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'd3);          // E0
        idle();                     // E1
        chk_irq("ar_e1", 1'b0);
        idle();                     // E2 expiry
        chk_irq("ar_e2", 1'b1);
        wr(A_STATUS, 32'd1);        // E3
        chk_irq("ar_e3_clr", 1'b0);
        wr(A_STATUS, 32'd1);        // E4 expiry beats clear
        chk_irq("ar_e4_prio", 1'b1);
        wr(A_STATUS, 32'd1);        // E5
        chk_irq("ar_e5_clr", 1'b0);
        idle();                     // E6 expiry
        chk_irq("ar_e6", 1'b1);
        wr(A_CTRL, 32'd0);          // stop, PEND kept
        chk_irq("ar_stop", 1'b1);
        wr(A_STATUS, 32'd1);
        idle();
        idle();
        chk_irq("ar_idle", 1'b0);

        // Enable write on the expiry edge reloads without PEND
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd1);          // E0 count=2
        idle();                     // E1 count=1
        idle();                     // E2 count=0
        wr(A_CTRL, 32'd1);          // E3 would expire
        chk_irq("en_prio_irq", 1'b0);
        reg_rd("en_prio_c2", A_COUNT, 32'd2);
        reg_rd("en_prio_c1", A_COUNT, 32'd1);
        reg_rd("en_prio_c0", A_COUNT, 32'd0);
        chk_irq("en_prio_exp", 1'b1);
        wr(A_STATUS, 32'd1);

        // Full-scale LOAD, then hold on disable
        wr(A_LOAD, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'd1);
        reg_rd("max_c0", A_COUNT, 32'hFFFF_FFFF);
        reg_rd("max_c1", A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'd0);
        reg_rd("max_hold0", A_COUNT, 32'hFFFF_FFFD);
        reg_rd("max_hold1", A_COUNT, 32'hFFFF_FFFD);

        // LOAD written mid-run does not disturb the running count
        wr(A_LOAD, 32'd5);
        wr(A_CTRL, 32'd1);          // E0 count=5
        wr(A_LOAD, 32'd1);          // E1 count=4
        reg_rd("ldrun_cnt", A_COUNT, 32'd3 + 32'd1);
        wr(A_CTRL, 32'd0);

        // Random one-shot periods: PEND exactly LOAD+1 edges after enable
        for (int it = 0; it < 5; it++) begin
            L = (it == 0) ? 0 : int'($urandom_range(1, 12));
            wr(A_LOAD, 32'(L));
            wr(A_CTRL, 32'd1);
            for (int k = 0; k < L; k++) idle();
            chk_irq("rnd_pre", 1'b0);
            idle();
            chk_irq("rnd_exp", 1'b1);
            wr(A_STATUS, 32'd1);
            chk_irq("rnd_clr", 1'b0);
        end

        // Reset in the middle of a long count
        ram_wr(14'h0020, 32'hCAFE_F00D);
        wr(A_LOAD, 32'd100);
        wr(A_CTRL, 32'd1);
        for (int k = 0; k < 9; k++) idle();
        rst = 1'b1;
        cyc(1'b1, 14'h0020, 32'h1111_1111);
        chk("mr_data", dout, 32'd0);
        chk_irq("mr_irq", 1'b0);
        rst = 1'b0;
        reg_rd("mr_count", A_COUNT, 32'd0);
        reg_rd("mr_ctrl",  A_CTRL,  32'd0);
        reg_rd("mr_load",  A_LOAD,  32'd0);
        for (int k = 0; k < 110; k++) idle();
        chk_irq("mr_noexp", 1'b0);
        ram_rd("mr_ram20", 14'h0020);
        ram_rd("mr_ram5",  14'h0005);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
